// File: rtl/food_placer_pkg.sv
// Shared board geometry, derived widths and the placement FSM state type.
// The food placer, its cell-step helper and the bench all import this package.
package food_placer_pkg;

    localparam int BOARD_WIDTH       = 32;
    localparam int BOARD_HEIGHT      = 24;
    localparam int BOARD_WIDTH_BITS  = 5;
    localparam int BOARD_HEIGHT_BITS = 5;
    localparam int BOARD_CELLS       = BOARD_WIDTH * BOARD_HEIGHT;

    // Must be able to hold BOARD_CELLS itself, not just BOARD_CELLS-1.
    localparam int SCAN_BITS = $clog2(BOARD_CELLS + 1);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOOKUP      = 3'd1,
        ST_CHECK       = 3'd2,
        ST_SCAN_LOOKUP = 3'd3,
        ST_SCAN_CHECK  = 3'd4
    } place_state_e;

endpackage

// File: rtl/board_cell_next.sv
// Combinational raster step across the board: x advances first, then y.
// Both axes wrap, so repeated steps visit every cell once before repeating.
module board_cell_next
    import food_placer_pkg::*;
(
    input  logic [BOARD_WIDTH_BITS-1:0]  x_i,
    input  logic [BOARD_HEIGHT_BITS-1:0] y_i,
    output logic [BOARD_WIDTH_BITS-1:0]  next_x_o,
    output logic [BOARD_HEIGHT_BITS-1:0] next_y_o
);

    localparam logic [BOARD_WIDTH_BITS-1:0]  X_LAST = BOARD_WIDTH_BITS'(BOARD_WIDTH - 1);
    localparam logic [BOARD_HEIGHT_BITS-1:0] Y_LAST = BOARD_HEIGHT_BITS'(BOARD_HEIGHT - 1);

    always_comb begin
        next_x_o = x_i + BOARD_WIDTH_BITS'(1);
        next_y_o = y_i;
        if (x_i == X_LAST) begin
            next_x_o = '0;
            if (y_i == Y_LAST) begin
                next_y_o = '0;
            end else begin
                next_y_o = y_i + BOARD_HEIGHT_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/food_placer.sv
// Picks a free food cell: up to MAX_TRIES random probes of the occupancy RAM,
// then a wrapping linear scan starting after the last random candidate.
module food_placer
    import food_placer_pkg::*;
#(
    parameter int MAX_TRIES = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         place_req,
    input  logic [BOARD_WIDTH_BITS-1:0]  rand_x,
    input  logic [BOARD_HEIGHT_BITS-1:0] rand_y,
    output logic [BOARD_WIDTH_BITS-1:0]  occ_rd_x,
    output logic [BOARD_HEIGHT_BITS-1:0] occ_rd_y,
    input  logic                         occ_rd_data,
    output logic [BOARD_WIDTH_BITS-1:0]  food_x,
    output logic [BOARD_HEIGHT_BITS-1:0] food_y,
    output logic                         food_valid,
    output logic                         place_done,
    output logic                         board_full,
    output logic                         busy
);

    localparam int TRIES_BITS = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRIES_BITS-1:0] LAST_TRY  = TRIES_BITS'(MAX_TRIES - 1);
    localparam logic [SCAN_BITS-1:0]  SCAN_LAST = SCAN_BITS'(BOARD_CELLS);

    place_state_e                 state_q;
    logic [BOARD_WIDTH_BITS-1:0]  cand_x_q;
    logic [BOARD_HEIGHT_BITS-1:0] cand_y_q;
    logic [BOARD_WIDTH_BITS-1:0]  food_x_q;
    logic [BOARD_HEIGHT_BITS-1:0] food_y_q;
    logic                         food_valid_q;
    logic                         place_done_q;
    logic                         board_full_q;
    logic                         busy_q;
    logic [TRIES_BITS-1:0]        tries_q;
    logic [SCAN_BITS-1:0]         scan_q;

    logic [BOARD_WIDTH_BITS-1:0]  step_x_d;
    logic [BOARD_HEIGHT_BITS-1:0] step_y_d;

    board_cell_next u_cell_next (
        .x_i      (cand_x_q),
        .y_i      (cand_y_q),
        .next_x_o (step_x_d),
        .next_y_o (step_y_d)
    );

    // The candidate register doubles as the RAM read address, so data
    // arriving in a CHECK state always belongs to the current candidate.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            place_done_q <= 1'b0;
            board_full_q <= 1'b0;
            busy_q       <= 1'b0;
            tries_q      <= '0;
            scan_q       <= '0;
        end else begin
            place_done_q <= 1'b0;
            board_full_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (place_req) begin
                        cand_x_q     <= rand_x;
                        cand_y_q     <= rand_y;
                        tries_q      <= '0;
                        food_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (!occ_rd_data) begin
                        food_x_q     <= cand_x_q;
                        food_y_q     <= cand_y_q;
                        food_valid_q <= 1'b1;
                        place_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else if (tries_q != LAST_TRY) begin
                        tries_q  <= tries_q + TRIES_BITS'(1);
                        cand_x_q <= rand_x;
                        cand_y_q <= rand_y;
                        state_q  <= ST_LOOKUP;
                    end else begin
                        cand_x_q <= step_x_d;
                        cand_y_q <= step_y_d;
                        scan_q   <= SCAN_BITS'(1);
                        state_q  <= ST_SCAN_LOOKUP;
                    end
                end
                ST_SCAN_LOOKUP: begin
                    state_q <= ST_SCAN_CHECK;
                end
                ST_SCAN_CHECK: begin
                    if (!occ_rd_data) begin
                        food_x_q     <= cand_x_q;
                        food_y_q     <= cand_y_q;
                        food_valid_q <= 1'b1;
                        place_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else if (scan_q < SCAN_LAST) begin
                        cand_x_q <= step_x_d;
                        cand_y_q <= step_y_d;
                        scan_q   <= scan_q + SCAN_BITS'(1);
                        state_q  <= ST_SCAN_LOOKUP;
                    end else begin
                        // Scan wrapped back onto the last random candidate.
                        board_full_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign occ_rd_x   = cand_x_q;
    assign occ_rd_y   = cand_y_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign place_done = place_done_q;
    assign board_full = board_full_q;
    assign busy       = busy_q;

    a_pulses_exclusive : assert property (@(posedge clk) disable iff (!reset)
        !(place_done_q && board_full_q));
    a_busy_tracks_state : assert property (@(posedge clk) disable iff (!reset)
        busy_q == (state_q != ST_IDLE));

endmodule
